exc_unit: RTL and testbench

EXC_UNIT -- requirements
Module: exc_unit

---
 rtl/exc_unit.sv | 155 +++++++++++++++
 tb/tb_exc_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_unit.sv
// Exception/ERET commit unit: picks the highest-priority cause at the memory
// stage, drives CP0 event controls, fetch redirect and a timed pipeline flush.
module exc_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m_valid,
  input  logic        stall,
  input  logic [31:0] m_pc,
  input  logic        m_is_branch,
  input  logic        m_if_adel,
  input  logic        m_ri,
  input  logic        m_sys,
  input  logic        m_bp,
  input  logic        m_ov,
  input  logic        m_adel,
  input  logic        m_ades,
  input  logic        m_eret,
  input  logic [31:0] m_data_addr,
  input  logic        interrupt,
  input  logic [31:0] cp0_epc,
  output logic        exception,
  output logic        isBadAddr,
  output logic        inDelaySlot,
  output logic        ERET2pc,
  output logic [5:0]  m_excCode,
  output logic [31:0] invalid_addr,
  output logic [31:0] excPC,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic        ds_flag, ds_flag_n;

  logic        commit;
  logic        has_cause;
  logic [4:0]  code;
  logic        bad;
  logic [31:0] bad_addr;
  logic        exc_ev;
  logic        eret_ev;

  // resetn gating keeps outputs quiet while reset is held
  assign commit  = resetn & m_valid & ~stall & (state == S_RUN);
  assign exc_ev  = commit & has_cause;
  assign eret_ev = commit & m_eret & ~has_cause;

  always_comb begin
    has_cause = 1'b0;
    code      = 5'd0;
    bad       = 1'b0;
    bad_addr  = 32'd0;
    priority case (1'b1)
      interrupt: begin
        has_cause = 1'b1;
        code      = 5'd0;
      end
      m_if_adel: begin
        has_cause = 1'b1;
        code      = 5'd4;
        bad       = 1'b1;
        bad_addr  = m_pc;
      end
      m_ri: begin
        has_cause = 1'b1;
        code      = 5'd10;
      end
      m_sys: begin
        has_cause = 1'b1;
        code      = 5'd8;
      end
      m_bp: begin
        has_cause = 1'b1;
        code      = 5'd9;
      end
      m_ov: begin
        has_cause = 1'b1;
        code      = 5'd12;
      end
      m_adel: begin
        has_cause = 1'b1;
        code      = 5'd4;
        bad       = 1'b1;
        bad_addr  = m_data_addr;
      end
      m_ades: begin
        has_cause = 1'b1;
        code      = 5'd5;
        bad       = 1'b1;
        bad_addr  = m_data_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    exception      = exc_ev;
    ERET2pc        = eret_ev;
    m_excCode      = exc_ev ? {1'b0, code} : 6'd0;
    isBadAddr      = exc_ev & bad;
    invalid_addr   = (exc_ev & bad) ? bad_addr : 32'd0;
    excPC          = exc_ev ? m_pc : 32'd0;
    inDelaySlot    = exc_ev & ds_flag;
    redirect_valid = exc_ev | eret_ev;
    redirect_pc    = 32'd0;
    if (exc_ev)
      redirect_pc = EXC_VECTOR;
    else if (eret_ev)
      redirect_pc = cp0_epc;
    flush = resetn & ((state == S_FLUSH) | exc_ev | eret_ev);
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ds_flag_n = ds_flag;
    unique case (state)
      S_RUN: begin
        if (exc_ev | eret_ev) begin
          state_n   = S_FLUSH;
          cnt_n     = 3'(FLUSH_CYCLES);
          ds_flag_n = 1'b0;
        end else if (commit) begin
          ds_flag_n = m_is_branch;
        end
      end
      S_FLUSH: begin
        cnt_n = cnt - 3'd1;
        if (cnt == 3'd1)
          state_n = S_RUN;
      end
      default: state_n = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_RUN;
      cnt     <= 3'd0;
      ds_flag <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ds_flag <= ds_flag_n;
    end
  end

endmodule

// File: tb/tb_exc_unit.sv
// Directed bench for exc_unit: causes, priority, delay slot, ERET,
// stall hold, flush length and reset abort.
module tb_exc_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m_valid, stall, m_is_branch;
  logic [31:0] m_pc, m_data_addr, cp0_epc;
  logic        m_if_adel, m_ri, m_sys, m_bp, m_ov;
  logic        m_adel, m_ades, m_eret, interrupt;
  logic        exception, isBadAddr, inDelaySlot, ERET2pc;
  logic [5:0]  m_excCode;
  logic [31:0] invalid_addr, excPC, redirect_pc;
  logic        flush, redirect_valid;

  int n_chk = 0;
  int n_err = 0;

  exc_unit dut (
    .clk(clk), .resetn(resetn),
    .m_valid(m_valid), .stall(stall),
    .m_pc(m_pc), .m_is_branch(m_is_branch),
    .m_if_adel(m_if_adel), .m_ri(m_ri),
    .m_sys(m_sys), .m_bp(m_bp), .m_ov(m_ov),
    .m_adel(m_adel), .m_ades(m_ades),
    .m_eret(m_eret), .m_data_addr(m_data_addr),
    .interrupt(interrupt), .cp0_epc(cp0_epc),
    .exception(exception), .isBadAddr(isBadAddr),
    .inDelaySlot(inDelaySlot), .ERET2pc(ERET2pc),
    .m_excCode(m_excCode),
    .invalid_addr(invalid_addr), .excPC(excPC),
    .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    m_valid = 0; stall = 0; m_is_branch = 0;
    m_pc = 0; m_data_addr = 0; cp0_epc = 0;
    m_if_adel = 0; m_ri = 0; m_sys = 0; m_bp = 0;
    m_ov = 0; m_adel = 0; m_ades = 0; m_eret = 0;
    interrupt = 0;
  endtask

  // advance one clock, inputs change 1ns after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drain();
    idle();
    repeat (3) cyc();
  endtask

  initial begin
    idle();
    resetn = 0;
    cyc();
    m_valid = 1; m_ov = 1; interrupt = 1;
    settle();
    chk("rst_exc_held", 32'(exception), 0);
    chk("rst_flush_held", 32'(flush), 0);
    cyc();
    idle();
    resetn = 1;
    settle();
    chk("rst_exc", 32'(exception), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_rv", 32'(redirect_valid), 0);
    cyc();

    // overflow commit, flush length
    m_valid = 1; m_pc = 32'h8000_0010; m_ov = 1;
    settle();
    chk("ov_exc", 32'(exception), 1);
    chk("ov_code", 32'(m_excCode), 12);
    chk("ov_epc", excPC, 32'h8000_0010);
    chk("ov_rpc", redirect_pc, 32'hBFC0_0380);
    chk("ov_rv", 32'(redirect_valid), 1);
    chk("ov_bad", 32'(isBadAddr), 0);
    chk("ov_ds", 32'(inDelaySlot), 0);
    chk("ov_fl0", 32'(flush), 1);
    cyc();
    settle();
    chk("ov_fl1", 32'(flush), 1);
    chk("ov_rv1", 32'(redirect_valid), 0);
    chk("ov_exc1", 32'(exception), 0);
    cyc();
    settle();
    chk("ov_fl2", 32'(flush), 1);
    cyc();
    idle();
    settle();
    chk("ov_fl3", 32'(flush), 0);

    // branch, bubble, then load address error in delay slot
    m_valid = 1; m_pc = 32'h8000_0100; m_is_branch = 1;
    settle();
    chk("br_exc", 32'(exception), 0);
    chk("br_flush", 32'(flush), 0);
    cyc();
    idle();
    cyc();
    m_valid = 1; m_pc = 32'h8000_0104;
    m_adel = 1; m_data_addr = 32'h0000_0003;
    settle();
    chk("adel_ds", 32'(inDelaySlot), 1);
    chk("adel_code", 32'(m_excCode), 4);
    chk("adel_bad", 32'(isBadAddr), 1);
    chk("adel_addr", invalid_addr, 32'h0000_0003);
    cyc();
    drain();

    // priority: interrupt over ri/sys
    m_valid = 1; m_pc = 32'h8000_0300;
    m_ri = 1; m_sys = 1; interrupt = 1;
    settle();
    chk("irq_code", 32'(m_excCode), 0);
    chk("irq_exc", 32'(exception), 1);
    chk("irq_bad", 32'(isBadAddr), 0);
    chk("irq_addr", invalid_addr, 0);
    chk("irq_ds", 32'(inDelaySlot), 0);
    cyc();
    drain();

    // fetch address error beats ri
    m_valid = 1; m_pc = 32'h8000_0401;
    m_if_adel = 1; m_ri = 1; m_data_addr = 32'h1234;
    settle();
    chk("ifa_code", 32'(m_excCode), 4);
    chk("ifa_bad", 32'(isBadAddr), 1);
    chk("ifa_addr", invalid_addr, 32'h8000_0401);
    cyc();
    drain();

    // store address error
    m_valid = 1; m_ades = 1; m_data_addr = 32'h0000_0006;
    settle();
    chk("ades_code", 32'(m_excCode), 5);
    chk("ades_addr", invalid_addr, 32'h0000_0006);
    cyc();
    drain();

    // ERET
    m_valid = 1; m_eret = 1; cp0_epc = 32'h8000_0200;
    settle();
    chk("eret_e2p", 32'(ERET2pc), 1);
    chk("eret_exc", 32'(exception), 0);
    chk("eret_rpc", redirect_pc, 32'h8000_0200);
    chk("eret_rv", 32'(redirect_valid), 1);
    chk("eret_flush", 32'(flush), 1);
    cyc();
    drain();

    // ERET suppressed by overflow
    m_valid = 1; m_eret = 1; m_ov = 1;
    cp0_epc = 32'h8000_0200;
    settle();
    chk("eov_exc", 32'(exception), 1);
    chk("eov_e2p", 32'(ERET2pc), 0);
    chk("eov_rpc", redirect_pc, 32'hBFC0_0380);
    cyc();
    drain();

    // syscall held by stall, then commit; then ignored in FLUSH
    m_valid = 1; m_sys = 1; stall = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stl_exc", 32'(exception), 0);
      chk("stl_flush", 32'(flush), 0);
      cyc();
    end
    stall = 0;
    settle();
    chk("stl_exc4", 32'(exception), 1);
    chk("stl_code", 32'(m_excCode), 8);
    cyc();
    m_sys = 0; m_ov = 1; interrupt = 1;
    settle();
    chk("fl_exc", 32'(exception), 0);
    chk("fl_rv", 32'(redirect_valid), 0);
    chk("fl_flush", 32'(flush), 1);
    cyc();
    drain();

    // no valid instruction, no interrupt taken
    interrupt = 1;
    settle();
    chk("nov_exc", 32'(exception), 0);
    chk("nov_flush", 32'(flush), 0);
    cyc();
    idle();

    // reset aborts flush
    m_valid = 1; m_bp = 1;
    settle();
    chk("bp_code", 32'(m_excCode), 9);
    cyc();
    idle();
    resetn = 0;
    cyc();
    resetn = 1;
    settle();
    chk("rab_flush", 32'(flush), 0);

    // reset clears delay-slot flag
    m_valid = 1; m_is_branch = 1;
    cyc();
    idle();
    resetn = 0;
    cyc();
    resetn = 1;
    m_valid = 1; m_ov = 1;
    settle();
    chk("rds_exc", 32'(exception), 1);
    chk("rds_ds", 32'(inDelaySlot), 0);
    cyc();
    idle();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
